// File: rtl/uart_alu_frame_ctrl_pkg.sv
// Shared encodings for the UART <-> ALU frame controller.
package uart_alu_frame_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] ST_RX_A    = 3'd0;
    localparam logic [2:0] ST_RX_B    = 3'd1;
    localparam logic [2:0] ST_RX_OP   = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_TX_SEND = 3'd4;
    localparam logic [2:0] ST_TX_WAIT = 3'd5;

    typedef enum logic [2:0] {
        S_RX_A    = ST_RX_A,
        S_RX_B    = ST_RX_B,
        S_RX_OP   = ST_RX_OP,
        S_EXEC    = ST_EXEC,
        S_TX_SEND = ST_TX_SEND,
        S_TX_WAIT = ST_TX_WAIT
    } state_t;

    function automatic logic is_busy_state(input state_t s);
        return (s == S_EXEC) || (s == S_TX_SEND) || (s == S_TX_WAIT);
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and flags expiry.
module uart_frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] count;

    // A byte in the expiry cycle wins over the timeout.
    assign o_expire_c = (TIMEOUT_CYCLES != 0) && i_enable && !i_clear
                        && (count == CNT_W'(LAST));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (!i_enable || i_clear || o_expire_c) begin
            count <= '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Loads multi-byte little-endian operands/opcode from UART, commits them to the
// ALU atomically and streams the result back LSB-first.
module uart_alu_frame_ctrl
    import uart_alu_frame_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [BYTE_W-1:0]  i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [BYTE_W-1:0]  o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int unsigned BYTES = NB_DATA / BYTE_W;
    localparam int unsigned K_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BYTES - 1);

    state_t             state, state_nxt;
    logic [K_W-1:0]     k, k_nxt, k_inc;
    logic [NB_DATA-1:0] shadow_a, shadow_a_nxt;
    logic [NB_DATA-1:0] shadow_b, shadow_b_nxt;
    logic [NB_DATA-1:0] tx_hold, tx_hold_nxt;
    logic [NB_DATA-1:0] data_a_nxt, data_b_nxt;
    logic [NB_OP-1:0]   operation_nxt;
    logic [BYTE_W-1:0]  tx_data_nxt;
    logic               tx_start_nxt, busy_nxt, timeout_nxt;
    logic               frame_open_c, rx_accept_c, expire_c;

    assign k_inc        = k + K_W'(1);
    assign rx_accept_c  = i_rx_done && !is_busy_state(state);
    assign frame_open_c = ((state == S_RX_A) && (k != '0)) || (state == S_RX_B)
                          || (state == S_RX_OP);

    uart_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (frame_open_c),
        .i_clear    (rx_accept_c),
        .o_expire_c (expire_c)
    );

    // Next-state and next-output logic; every register has a hold default.
    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        shadow_a_nxt  = shadow_a;
        shadow_b_nxt  = shadow_b;
        tx_hold_nxt   = tx_hold;
        data_a_nxt    = o_data_a;
        data_b_nxt    = o_data_b;
        operation_nxt = o_operation;
        tx_data_nxt   = o_tx_data;
        tx_start_nxt  = 1'b0;
        timeout_nxt   = 1'b0;

        unique case (state)
            S_RX_A: begin
                if (i_rx_done) begin
                    shadow_a_nxt[{k, 3'b000} +: BYTE_W] = i_rx_data;
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = S_RX_B;
                    end else begin
                        k_nxt = k_inc;
                    end
                end
            end
            S_RX_B: begin
                if (i_rx_done) begin
                    shadow_b_nxt[{k, 3'b000} +: BYTE_W] = i_rx_data;
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = S_RX_OP;
                    end else begin
                        k_nxt = k_inc;
                    end
                end
            end
            S_RX_OP: begin
                if (i_rx_done) begin
                    data_a_nxt    = shadow_a;
                    data_b_nxt    = shadow_b;
                    operation_nxt = i_rx_data[NB_OP-1:0];
                    state_nxt     = S_EXEC;
                end
            end
            S_EXEC: begin
                // Result is registered here; first byte goes straight from the ALU.
                tx_hold_nxt  = i_alu_result;
                k_nxt        = '0;
                tx_data_nxt  = i_alu_result[BYTE_W-1:0];
                tx_start_nxt = 1'b1;
                state_nxt    = S_TX_SEND;
            end
            S_TX_SEND: begin
                state_nxt = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (i_tx_done) begin
                    if (k != K_LAST) begin
                        k_nxt        = k_inc;
                        tx_data_nxt  = tx_hold[{k_inc, 3'b000} +: BYTE_W];
                        tx_start_nxt = 1'b1;
                        state_nxt    = S_TX_SEND;
                    end else begin
                        state_nxt = S_RX_A;
                    end
                end
            end
            default: begin
                state_nxt = S_RX_A;
                k_nxt     = '0;
            end
        endcase

        // Stale partial frame: drop it, committed outputs untouched.
        if (expire_c) begin
            state_nxt    = S_RX_A;
            k_nxt        = '0;
            shadow_a_nxt = '0;
            shadow_b_nxt = '0;
            timeout_nxt  = 1'b1;
        end

        busy_nxt = is_busy_state(state_nxt);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= S_RX_A;
            k           <= '0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            tx_hold     <= '0;
            o_data_a    <= '0;
            o_data_b    <= '0;
            o_operation <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            shadow_a    <= shadow_a_nxt;
            shadow_b    <= shadow_b_nxt;
            tx_hold     <= tx_hold_nxt;
            o_data_a    <= data_a_nxt;
            o_data_b    <= data_b_nxt;
            o_operation <= operation_nxt;
            o_tx_data   <= tx_data_nxt;
            o_tx_start  <= tx_start_nxt;
            o_busy      <= busy_nxt;
            o_timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Scoreboard bench: 8-bit (timeout 16) and 16-bit (timeout off) controllers.
`timescale 1ns/1ps
module tb_uart_alu_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [7:0]  rx_data8, a8, b8, alu8, tx_data8;
    logic [5:0]  op8;
    logic        rx_done8, tx_start8, busy8, to8;
    logic        tx_done8 = 1'b0;

    logic [7:0]  rx_data16, tx_data16;
    logic [15:0] a16, b16, alu16;
    logic [5:0]  op16;
    logic        rx_done16, tx_start16, busy16, to16;
    logic        tx_done16 = 1'b0;

    // ALU models: opcode 0x20 adds, others subtract; 16-bit op 0x22 returns a marker.
    assign alu8  = (op8 == 6'h20) ? 8'(a8 + b8) : 8'(a8 - b8);
    assign alu16 = (op16 == 6'h22) ? 16'hBEEF : 16'(a16 + b16);

    uart_alu_frame_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut8 (
        .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data8), .i_rx_done(rx_done8),
        .o_data_a(a8), .o_data_b(b8), .o_operation(op8), .i_alu_result(alu8),
        .o_tx_data(tx_data8), .o_tx_start(tx_start8), .i_tx_done(tx_done8),
        .o_busy(busy8), .o_timeout(to8)
    );

    uart_alu_frame_ctrl #(.NB_DATA(16), .NB_OP(6), .TIMEOUT_CYCLES(0)) dut16 (
        .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data16), .i_rx_done(rx_done16),
        .o_data_a(a16), .o_data_b(b16), .o_operation(op16), .i_alu_result(alu16),
        .o_tx_data(tx_data16), .o_tx_start(tx_start16), .i_tx_done(tx_done16),
        .o_busy(busy16), .o_timeout(to16)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0] q8[$];
    logic [7:0] q16[$];
    int st_cnt8 = 0, st_cnt16 = 0, to_cnt8 = 0;
    bit pend8 = 1'b0, pend16 = 1'b0;
    bit tx_auto8 = 1'b1;

    // Tx monitors: pop the scoreboard on each start strobe; a second strobe
    // before tx_done is an ordering error.
    always @(negedge clk) begin
        if (!rst_n) pend8 = 1'b0;
        if (tx_start8) begin
            st_cnt8++;
            check_eq("tx8_order", 32'(pend8), 32'(0));
            pend8 = 1'b1;
            check_eq("tx8_expected", 32'(q8.size() != 0), 32'(1));
            if (q8.size() != 0) check_eq("tx8_data", 32'(tx_data8), 32'(q8.pop_front()));
        end
        if (tx_done8) pend8 = 1'b0;
        if (to8) to_cnt8++;
    end

    always @(negedge clk) begin
        if (!rst_n) pend16 = 1'b0;
        if (tx_start16) begin
            st_cnt16++;
            check_eq("tx16_order", 32'(pend16), 32'(0));
            pend16 = 1'b1;
            check_eq("tx16_expected", 32'(q16.size() != 0), 32'(1));
            if (q16.size() != 0) check_eq("tx16_data", 32'(tx_data16), 32'(q16.pop_front()));
        end
        if (tx_done16) pend16 = 1'b0;
    end

    // Transmitter models: finish each byte six cycles after its start strobe.
    always begin
        @(negedge clk);
        if (tx_start8 && tx_auto8) begin
            repeat (6) @(posedge clk);
            #1 tx_done8 = 1'b1;
            @(posedge clk);
            #1 tx_done8 = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        if (tx_start16) begin
            repeat (6) @(posedge clk);
            #1 tx_done16 = 1'b1;
            @(posedge clk);
            #1 tx_done16 = 1'b0;
        end
    end

    task automatic rx8(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data8 = b;
        rx_done8 = 1'b1;
        @(posedge clk);
        #1 rx_done8 = 1'b0;
    endtask

    task automatic rx16(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data16 = b;
        rx_done16 = 1'b1;
        @(posedge clk);
        #1 rx_done16 = 1'b0;
    endtask

    task automatic frame8(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        q8.push_back((op == 6'h20) ? 8'(a + b) : 8'(a - b));
        rx8(a);
        rx8(b);
        rx8({2'b00, op});
        check_eq("a8_commit", 32'(a8), 32'(a));
        check_eq("b8_commit", 32'(b8), 32'(b));
        check_eq("op8_commit", 32'(op8), 32'(op));
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("idle8", 32'(busy8), 32'(0));
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (busy16 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("idle16", 32'(busy16), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        logic [7:0] b16_bytes[4];

        rst_n     = 1'b0;
        rx_data8  = 8'h00;
        rx_done8  = 1'b0;
        rx_data16 = 8'h00;
        rx_done16 = 1'b0;
        #12;
        check_eq("rst_a8", 32'(a8), 32'(0));
        check_eq("rst_b8", 32'(b8), 32'(0));
        check_eq("rst_op8", 32'(op8), 32'(0));
        check_eq("rst_txd8", 32'(tx_data8), 32'(0));
        check_eq("rst_txs8", 32'(tx_start8), 32'(0));
        check_eq("rst_busy8", 32'(busy8), 32'(0));
        check_eq("rst_to8", 32'(to8), 32'(0));
        check_eq("rst_a16", 32'(a16), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 16-bit frame: outputs must stay put until the opcode byte.
        b16_bytes[0] = 8'h34; b16_bytes[1] = 8'h12;
        b16_bytes[2] = 8'hCD; b16_bytes[3] = 8'hAB;
        q16.push_back(8'hEF);
        q16.push_back(8'hBE);
        for (int i = 0; i < 4; i++) begin
            rx16(b16_bytes[i]);
            check_eq("a16_hold", 32'(a16), 32'(0));
            check_eq("b16_hold", 32'(b16), 32'(0));
        end
        rx16(8'h22);
        check_eq("a16_commit", 32'(a16), 32'h1234);
        check_eq("b16_commit", 32'(b16), 32'hABCD);
        check_eq("op16_commit", 32'(op16), 32'h22);
        check_eq("busy16", 32'(busy16), 32'(1));
        wait_idle16();
        check_eq("tx16_count", 32'(st_cnt16), 32'(2));

        // 8-bit frame with latency checks.
        frame8(8'h05, 8'h03, 6'h20);
        check_eq("busy8_exec", 32'(busy8), 32'(1));
        check_eq("txs8_exec", 32'(tx_start8), 32'(0));
        @(posedge clk);
        #1;
        check_eq("txs8_first", 32'(tx_start8), 32'(1));
        check_eq("txd8_first", 32'(tx_data8), 32'h08);
        wait_idle8();
        check_eq("tx8_count", 32'(st_cnt8), 32'(1));

        // Partial frame times out 16 cycles after its last byte.
        rx8(8'h05);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!to8 && cyc < 40);
        check_eq("to_latency", 32'(cyc), 32'(16));
        @(posedge clk);
        #1;
        check_eq("to_pulse_len", 32'(to8), 32'(0));
        check_eq("to_count", 32'(to_cnt8), 32'(1));
        check_eq("to_keep_a", 32'(a8), 32'h05);
        check_eq("to_keep_b", 32'(b8), 32'h03);
        check_eq("to_keep_op", 32'(op8), 32'h20);
        frame8(8'h01, 8'h02, 6'h20);
        wait_idle8();

        // Byte landing exactly in the expiry cycle is kept.
        base = to_cnt8;
        q8.push_back(8'h0E);
        rx8(8'h05);
        repeat (14) @(posedge clk);
        rx8(8'h09);
        rx8(8'h20);
        check_eq("edge_a8", 32'(a8), 32'h05);
        check_eq("edge_b8", 32'(b8), 32'h09);
        wait_idle8();
        check_eq("edge_no_to", 32'(to_cnt8), 32'(base));

        // Rx bytes during TX_WAIT are dropped.
        frame8(8'h02, 8'h06, 6'h20);
        repeat (2) @(posedge clk);
        rx8(8'h77);
        rx8(8'h77);
        check_eq("drop_busy", 32'(busy8), 32'(1));
        wait_idle8();
        frame8(8'h04, 8'h06, 6'h21);
        wait_idle8();

        // Async reset in TX_WAIT: outputs clear at once, no further strobe.
        tx_auto8 = 1'b0;
        frame8(8'h10, 8'h20, 6'h20);
        @(posedge clk);
        #1;
        check_eq("rst_pre_start", 32'(tx_start8), 32'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_a8", 32'(a8), 32'(0));
        check_eq("arst_b8", 32'(b8), 32'(0));
        check_eq("arst_op8", 32'(op8), 32'(0));
        check_eq("arst_txd8", 32'(tx_data8), 32'(0));
        check_eq("arst_busy8", 32'(busy8), 32'(0));
        base = st_cnt8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tx_auto8 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("arst_no_start", 32'(st_cnt8), 32'(base));
        check_eq("arst_idle", 32'(busy8), 32'(0));
        frame8(8'h02, 8'h03, 6'h20);
        wait_idle8();

        check_eq("q8_drained", 32'(q8.size()), 32'(0));
        check_eq("q16_drained", 32'(q16.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
